// File: rtl/hash_msg_feeder_if.sv
// hash_msg_feeder_if
//   Bundles every non-clock signal of the hash message feeder.
//   slave  : the feeder's view (consumes length/data, drives the hash core
//            byte stream and the result handshake).
//   master : the environment's view (mirror image of slave).
//   Signals:
//     s_len_valid/s_len_ready/s_len     64-bit message length handshake
//     s_data_valid/s_data_ready/s_data  32-bit data word handshake
//     M_valid/M/C_in                    byte stream and length to hash core
//     hash_ready/digest_out             hash core done flag and result
//     d_valid/d_ready/d_digest          captured result handshake
//     busy                              feeder not idle
`timescale 1ns/1ps
interface hash_msg_feeder_if;
  logic        s_len_valid;
  logic        s_len_ready;
  logic [63:0] s_len;
  logic        s_data_valid;
  logic        s_data_ready;
  logic [31:0] s_data;
  logic        M_valid;
  logic [7:0]  M;
  logic [63:0] C_in;
  logic        hash_ready;
  logic [63:0] digest_out;
  logic        d_valid;
  logic        d_ready;
  logic [63:0] d_digest;
  logic        busy;

  modport slave (
    input  s_len_valid, s_len, s_data_valid, s_data, hash_ready, digest_out, d_ready,
    output s_len_ready, s_data_ready, M_valid, M, C_in, d_valid, d_digest, busy
  );

  modport master (
    output s_len_valid, s_len, s_data_valid, s_data, hash_ready, digest_out, d_ready,
    input  s_len_ready, s_data_ready, M_valid, M, C_in, d_valid, d_digest, busy
  );
endinterface

// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder
//   Accepts a 64-bit message length and a stream of 32-bit data words and
//   feeds the message one byte per cycle to a hash core, then captures the
//   core's digest and offers it on a valid/ready result port.
//   Ports:
//     clk    : single clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : hash_msg_feeder_if.slave (length, data, byte stream, result)
//   Parameter:
//     LSB_FIRST : 1 = s_data[7:0] emitted first, 0 = s_data[31:24] first
`timescale 1ns/1ps
module hash_msg_feeder #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  hash_msg_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, ZERO, SEND, WAIT, OUT} state_t;

  state_t      state_q;
  logic [63:0] len_q;
  logic [63:0] words_left_q;
  logic [63:0] bytes_left_q;
  logic [63:0] d_digest_q;
  logic [31:0] buf_q;
  logic [2:0]  buf_cnt_q;
  logic        wait_first_q;
  logic        d_valid_q;

  logic        emit_d;
  logic        last_byte_d;
  logic        len_xfer_d;
  logic        data_xfer_d;
  logic [63:0] bytes_after_d;
  logic [63:0] words_init_d;
  logic [2:0]  load_cnt_d;
  logic [7:0]  cur_byte_d;

  assign emit_d      = (state_q == SEND) && (buf_cnt_q != 3'd0);
  assign last_byte_d = emit_d && (bytes_left_q == 64'd1);
  assign cur_byte_d  = LSB_FIRST ? buf_q[7:0] : buf_q[31:24];

  // Gated with rst_n so the length port is not ready while reset is held,
  // yet is ready in the very first cycle after release.
  assign bus.s_len_ready  = rst_n && (state_q == IDLE);
  // A new word may enter when the buffer is empty or draining its last byte,
  // which is what lets consecutive words stream without a bubble.
  assign bus.s_data_ready = (state_q == SEND) && (words_left_q != 64'd0) &&
                            (buf_cnt_q <= 3'd1);

  assign len_xfer_d  = bus.s_len_valid && bus.s_len_ready;
  assign data_xfer_d = bus.s_data_valid && bus.s_data_ready;

  // Bytes still owed after this cycle's emission; the final word only keeps
  // that many bytes, the rest of it is dropped.
  assign bytes_after_d = bytes_left_q - {63'd0, emit_d};
  assign load_cnt_d    = (bytes_after_d >= 64'd4) ? 3'd4 : bytes_after_d[2:0];

  // ceil(len/4) without the overflow of (len+3)>>2 at len = 2^64-1.
  assign words_init_d = {2'b00, bus.s_len[63:2]} + {63'd0, |bus.s_len[1:0]};

  assign bus.M_valid  = (state_q == ZERO) || emit_d;
  assign bus.M        = emit_d ? cur_byte_d : 8'h00;
  assign bus.C_in     = len_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.d_digest = d_digest_q;
  assign bus.busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      len_q        <= 64'd0;
      words_left_q <= 64'd0;
      bytes_left_q <= 64'd0;
      d_digest_q   <= 64'd0;
      buf_q        <= 32'd0;
      buf_cnt_q    <= 3'd0;
      wait_first_q <= 1'b0;
      d_valid_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (len_xfer_d) begin
            len_q        <= bus.s_len;
            bytes_left_q <= bus.s_len;
            words_left_q <= words_init_d;
            state_q      <= (bus.s_len == 64'd0) ? ZERO : SEND;
          end
        end
        ZERO: begin
          state_q      <= WAIT;
          wait_first_q <= 1'b1;
        end
        SEND: begin
          if (emit_d) begin
            bytes_left_q <= bytes_left_q - 64'd1;
            buf_cnt_q    <= buf_cnt_q - 3'd1;
            buf_q        <= LSB_FIRST ? (buf_q >> 8) : (buf_q << 8);
          end
          // A load only happens when the buffer is empty or just drained,
          // so it safely overrides the shift above.
          if (data_xfer_d) begin
            buf_q        <= bus.s_data;
            buf_cnt_q    <= load_cnt_d;
            words_left_q <= words_left_q - 64'd1;
          end
          if (last_byte_d) begin
            state_q      <= WAIT;
            wait_first_q <= 1'b1;
            buf_cnt_q    <= 3'd0;
          end
        end
        WAIT: begin
          // hash_ready may still be high from the previous message during
          // the first WAIT cycle, so it is only trusted afterwards.
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (bus.hash_ready) begin
            d_digest_q <= bus.digest_out;
            d_valid_q  <= 1'b1;
            state_q    <= OUT;
          end
        end
        OUT: begin
          if (bus.d_ready) begin
            d_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder
//   Drives messages into hash_msg_feeder, models the hash core (hash_ready
//   level behaviour and digest), and compares the emitted byte stream and
//   captured digest with values computed directly from length and words.
`timescale 1ns/1ps
module tb_hash_msg_feeder;

  logic clk;
  logic rst_n;

  hash_msg_feeder_if bus();

  hash_msg_feeder #(.LSB_FIRST(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] words_q[$];
  logic [7:0]  got_q[$];

  typedef struct {
    logic [63:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          dly;
    logic [63:0] digest;
    int          exp_n;
    logic [63:0] exp_bytes;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One message: len, data words from words_q, gap mode (0 none, 1 toggle,
  // 2 random), d_ready delay, core latency, core digest, abort after N bytes.
  task automatic run_msg(input logic [63:0] len, input int gap, input int dly,
                         input int lat, input logic [63:0] dig, input int abort_at);
    logic [63:0] nw64;
    int          nw, nexp, widx, xfers, k, since_last, dcnt, first_cyc, last_cyc;
    bit          len_done, seen_first, in_out, done;
    logic [7:0]  exp_q[$];
    logic [31:0] w;

    nw64 = (len / 64'd4) + (((len % 64'd4) != 64'd0) ? 64'd1 : 64'd0);
    nw   = (nw64 > 64'(words_q.size())) ? words_q.size() : int'(nw64);
    if (len == 64'd0)              nexp = 1;
    else if (len > 64'(4 * nw))    nexp = 4 * nw;
    else                           nexp = int'(len);
    for (int i = 0; i < nexp; i++) begin
      if (len == 64'd0) exp_q.push_back(8'h00);
      else begin
        w = words_q[i / 4];
        exp_q.push_back(8'(w >> (8 * (i % 4))));
      end
    end

    got_q.delete();
    widx = 0; xfers = 0; k = 0; since_last = 0; dcnt = 0;
    first_cyc = -1; last_cyc = -1;
    len_done = 0; seen_first = 0; in_out = 0; done = 0;

    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      @(negedge clk);
      if (bus.M_valid) begin
        got_q.push_back(bus.M);
        if (!seen_first) begin
          seen_first = 1; first_cyc = cyc; k = 0;
          check("busy_sending", 64'(bus.busy), 64'd1);
        end
        last_cyc = cyc;
      end

      if (abort_at >= 0 && got_q.size() == abort_at) begin
        if (abort_at % 4 == 0) check("ready_before_abort", 64'(bus.s_data_ready), 64'd1);
        check("c_in_before_abort", bus.C_in, len);
        rst_n = 1'b0;
        #1;
        check("abort_m_valid", 64'(bus.M_valid), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_c_in", bus.C_in, 64'd0);
        check("abort_len_ready", 64'(bus.s_len_ready), 64'd0);
        check("abort_data_ready", 64'(bus.s_data_ready), 64'd0);
        @(negedge clk);
        bus.s_len_valid = 1'b0; bus.s_data_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("len_ready_after_release", 64'(bus.s_len_ready), 64'd1);
        done = 1;
      end else if (bus.d_valid) begin
        if (!in_out) begin
          in_out = 1;
          check("digest", bus.d_digest, dig);
          check("c_in", bus.C_in, len);
        end else begin
          check("digest_hold", bus.d_digest, dig);
        end
        check("len_ready_in_out", 64'(bus.s_len_ready), 64'd0);
        bus.d_ready = (dcnt == dly);
        dcnt++;
      end else if (in_out) begin
        check("dvalid_cycles", 64'(dcnt), 64'(dly + 1));
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_len_ready", 64'(bus.s_len_ready), 64'd1);
        bus.d_ready = 1'b0;
        done = 1;
      end

      if (!done) begin
        // Hash core: drops hash_ready one cycle after its first accepted
        // byte, raises it again with the digest once the message is in.
        if (seen_first) begin
          if (k == 2) begin
            bus.hash_ready = 1'b0;
            bus.digest_out = {$urandom(), $urandom()};
          end else if (k >= 3 && !bus.hash_ready) begin
            if (got_q.size() >= nexp && since_last >= lat) begin
              bus.hash_ready = 1'b1;
              bus.digest_out = dig;
            end else begin
              bus.digest_out = {$urandom(), $urandom()};
            end
          end
          if (got_q.size() >= nexp) since_last++;
          k++;
        end

        bus.s_len_valid = !len_done;
        bus.s_len = len_done ? {$urandom(), $urandom()} : len;
        if (widx < nw) begin
          bus.s_data = words_q[widx];
          bus.s_data_valid = (gap == 0) || (gap == 1 && cyc % 2 == 0) ||
                             (gap == 2 && $urandom_range(1) == 1);
        end else begin
          bus.s_data = 32'hDEADBEEF;
          bus.s_data_valid = 1'b1;
        end

        if (bus.s_len_valid && bus.s_len_ready) len_done = 1;
        if (bus.s_data_valid && bus.s_data_ready) begin
          xfers++;
          if (widx < nw) widx++;
        end
      end
    end

    bus.s_len_valid = 1'b0;
    bus.s_data_valid = 1'b0;
    bus.d_ready = 1'b0;

    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL msg_timeout: got no completion expected done within 2000 cycles (len=%0d)", len);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else if (abort_at < 0) begin
      check("byte_count", 64'(got_q.size()), 64'(nexp));
      for (int i = 0; i < nexp && i < got_q.size(); i++)
        check($sformatf("byte_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      check("words_taken", 64'(xfers), 64'(nw));
      if (gap == 0 && len != 64'd0)
        check("no_bubble", 64'(last_cyc - first_cyc), 64'(nexp - 1));
    end else begin
      for (int i = 0; i < got_q.size() && i < nexp; i++)
        check($sformatf("abort_byte_%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
    end
    $display("msg len=%0d bytes=%0d words=%0d digest=%h abort=%0d",
             len, got_q.size(), xfers, dig, abort_at);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [63:0] act;
    logic [63:0] rlen;
    int          nwr;

    vecs[0] = '{64'd5, 32'h44332211, 32'h00000055, 0, 0, 64'hA5A5_0000_1111_2222, 5, 64'h0000_0055_4433_2211};
    vecs[1] = '{64'd0, 32'h12345678, 32'h9ABCDEF0, 0, 0, 64'h0123_4567_89AB_CDEF, 1, 64'h0};
    vecs[2] = '{64'd8, 32'h87654321, 32'h0FEDCBA9, 1, 1, 64'h5555_6666_7777_8888, 8, 64'h0FED_CBA9_8765_4321};
    vecs[3] = '{64'd1, 32'h000000AB, 32'h0, 0, 0, 64'hDEAD_0000_BEEF_0001, 1, 64'h0000_0000_0000_00AB};
    vecs[4] = '{64'd6, 32'hA1B2C3D4, 32'h9999E5F6, 0, 10, 64'h1357_9BDF_2468_ACE0, 6, 64'h0000_E5F6_A1B2_C3D4};
    vecs[5] = '{64'd3, 32'h77CCBBAA, 32'h0, 2, 2, 64'hFACE_CAFE_0BAD_F00D, 3, 64'h0000_0000_00CC_BBAA};

    rst_n = 1'b0;
    bus.s_len_valid = 1'b1;
    bus.s_len = 64'd123;
    bus.s_data_valid = 1'b1;
    bus.s_data = 32'h11111111;
    bus.hash_ready = 1'b1;
    bus.digest_out = 64'hFEED_FEED_FEED_FEED;
    bus.d_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_len_ready", 64'(bus.s_len_ready), 64'd0);
    check("rst_data_ready", 64'(bus.s_data_ready), 64'd0);
    check("rst_m_valid", 64'(bus.M_valid), 64'd0);
    check("rst_d_valid", 64'(bus.d_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_c_in", bus.C_in, 64'd0);
    check("rst_m", 64'(bus.M), 64'd0);
    check("rst_d_digest", bus.d_digest, 64'd0);
    bus.s_len_valid = 1'b0;
    bus.s_data_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("release_len_ready", 64'(bus.s_len_ready), 64'd1);

    for (int v = 0; v < 6; v++) begin
      words_q = '{vecs[v].w0, vecs[v].w1};
      run_msg(vecs[v].len, vecs[v].gap, vecs[v].dly, 2, vecs[v].digest, -1);
      check($sformatf("vec%0d_nbytes", v), 64'(got_q.size()), 64'(vecs[v].exp_n));
      act = 64'd0;
      for (int i = 0; i < got_q.size() && i < 8; i++) act[8*i +: 8] = got_q[i];
      check($sformatf("vec%0d_bytes", v), act, vecs[v].exp_bytes);
    end

    // Reset after the 3rd byte of a 16-byte message, then a normal 4-byte one.
    words_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    run_msg(64'd16, 0, 0, 2, 64'h1111_2222_3333_4444, 3);
    check("abort_bytes", 64'(got_q.size()), 64'd3);
    words_q = '{32'hC0DEC0DE};
    run_msg(64'd4, 0, 1, 3, 64'h4444_3333_2222_1111, -1);

    // Maximum length: word count must not wrap to zero.
    words_q = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    run_msg(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2, 64'h0, 12);
    check("maxlen_bytes", 64'(got_q.size()), 64'd12);

    for (int r = 0; r < 16; r++) begin
      rlen = ($urandom_range(7) == 0) ? 64'd0 : 64'($urandom_range(1, 40));
      nwr = int'((rlen + 64'd3) / 64'd4);
      words_q.delete();
      for (int i = 0; i < nwr; i++) words_q.push_back($urandom());
      run_msg(rlen, $urandom_range(2), $urandom_range(4), $urandom_range(5),
              {$urandom(), $urandom()}, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
